// File: rtl/ex_muldiv_ctrl.sv
// Iterative 32-step multiply/divide sequencer with HI/LO ownership and pipeline stall generation.
// Shift-add multiply and restoring divide share one accumulator pair; signs are fixed up in FIX.
module ex_muldiv_ctrl #(
    parameter int NB_DATA = 32,
    parameter int NB_OP   = 2,
    parameter int NB_CNT  = 6
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_OP-1:0]   i_op,
    input  logic [NB_DATA-1:0] i_data_a,
    input  logic [NB_DATA-1:0] i_data_b,
    input  logic               i_mthi,
    input  logic               i_mtlo,
    input  logic               i_mf_req,
    output logic [NB_DATA-1:0] o_hi,
    output logic [NB_DATA-1:0] o_lo,
    output logic               o_busy,
    output logic               o_stall,
    output logic               o_done
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    localparam logic [NB_CNT-1:0] LAST_ITER = NB_CNT'(NB_DATA - 1);

    state_t             state, state_next;
    logic [NB_CNT-1:0]  cnt;
    logic [NB_DATA-1:0] acc_hi, acc_lo, operand;
    logic               is_div, sign_a, sign_b, div_zero;

    logic [NB_DATA:0]   mul_sum, rem_shift, rem_diff;
    logic [NB_DATA-1:0] step_hi, step_lo;
    logic               start_div_zero;

    function automatic logic [NB_DATA-1:0] neg_if(input logic [NB_DATA-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*NB_DATA-1:0] neg_if_wide(input logic [2*NB_DATA-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign start_div_zero = i_op[1] && (i_data_b == '0);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start) state_next = start_div_zero ? FIX : RUN;
            RUN:     if (cnt == LAST_ITER) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One iteration: multiply adds the multiplicand when the low bit is set and shifts right;
    // divide shifts the dividend into the remainder and keeps the subtraction if it does not borrow.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        rem_shift = {acc_hi, acc_lo[NB_DATA-1]};
        rem_diff  = rem_shift - {1'b0, operand};
        step_hi   = mul_sum[NB_DATA:1];
        step_lo   = {mul_sum[0], acc_lo[NB_DATA-1:1]};
        if (is_div) begin
            if (!rem_diff[NB_DATA]) begin
                step_hi = rem_diff[NB_DATA-1:0];
                step_lo = {acc_lo[NB_DATA-2:0], 1'b1};
            end else begin
                step_hi = rem_shift[NB_DATA-1:0];
                step_lo = {acc_lo[NB_DATA-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state  <= IDLE;
            cnt    <= '0;
            o_busy <= 1'b0;
        end else begin
            state  <= state_next;
            o_busy <= (state_next != IDLE);
            if (state == RUN) cnt <= cnt + 1'b1;
            else              cnt <= '0;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            acc_hi   <= '0;
            acc_lo   <= '0;
            operand  <= '0;
            is_div   <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            o_hi     <= '0;
            o_lo     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        is_div   <= i_op[1];
                        sign_a   <= i_op[0] & i_data_a[NB_DATA-1];
                        sign_b   <= i_op[0] & i_data_b[NB_DATA-1];
                        div_zero <= start_div_zero;
                        operand  <= neg_if(i_data_b, i_op[0] & i_data_b[NB_DATA-1]);
                        // Divide-by-zero keeps the raw dividend so HI can return it untouched.
                        acc_hi   <= start_div_zero ? i_data_a : '0;
                        acc_lo   <= neg_if(i_data_a, i_op[0] & i_data_a[NB_DATA-1]);
                    end else begin
                        if (i_mthi) o_hi <= i_data_a;
                        if (i_mtlo) o_lo <= i_data_a;
                    end
                end
                RUN: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                end
                FIX: begin
                    if (div_zero) begin
                        o_hi <= acc_hi;
                        o_lo <= '1;
                    end else if (is_div) begin
                        o_hi <= neg_if(acc_hi, sign_a);
                        o_lo <= neg_if(acc_lo, sign_a ^ sign_b);
                    end else begin
                        {o_hi, o_lo} <= neg_if_wide({acc_hi, acc_lo}, sign_a ^ sign_b);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_done  = (state == FIX);
    assign o_stall = (i_start & (state == IDLE)) | o_busy | (i_mf_req & o_busy);

endmodule

// File: doc/ex_muldiv_ctrl.md
Name: ex_muldiv_ctrl

Overview:
- Sequencer for an iterative 32-bit multiply/divide unit beside the EX-stage ALU.
- Accepts MULT/MULTU/DIV/DIVU issued from EX and runs a 32-step shift-add multiplier or restoring divider.
- Owns the HI/LO registers and services MTHI/MTLO.
- Drives a stall to the hazard logic so IF/ID/EX hold while the unit is busy or a MFHI/MFLO would read stale data.

Parameters:
NB_DATA, 32, operand/HI/LO width
NB_OP, 2, operation select width
NB_CNT, 6, iteration counter width (must hold NB_DATA)

Ports:
i_clock  in  1  system clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_start  in  1  launch operation (EX stage holds a mul/div)
i_op  in  NB_OP  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
i_data_a  in  NB_DATA  rs operand (multiplicand/dividend); post-forwarding value
i_data_b  in  NB_DATA  rt operand (multiplier/divisor); post-forwarding value
i_mthi  in  1  write i_data_a to HI
i_mtlo  in  1  write i_data_a to LO
i_mf_req  in  1  EX holds MFHI/MFLO
o_hi  out  NB_DATA  HI register
o_lo  out  NB_DATA  LO register
o_busy  out  1  registered, high in RUN/FIX
o_stall  out  1  combinational pipeline hold request
o_done  out  1  one-cycle pulse on the cycle HI/LO are written by an operation

Behaviour:
- Reset (i_reset=0, asynchronous): state IDLE, counter 0, o_hi=o_lo=0, o_busy=0, o_done=0, internal accumulators 0. Takes effect immediately, including mid-operation; the aborted result is discarded.
- FSM states:
  - IDLE: on i_start, capture op, operand magnitudes and sign flags; go to RUN with counter=0. For a divide with i_data_b=0, go directly to FIX.
  - RUN: one iteration per cycle; counter increments; after iteration 31 (counter==NB_DATA-1), go to FIX.
  - FIX: apply sign correction, write HI/LO, pulse o_done, go to IDLE.
- Latency:
  - Start sampled at edge E0; RUN occupies cycles E0..E31; FIX ends at E33, when HI/LO update. New values are visible from cycle 34 after start.
  - Divide-by-zero: FIX ends at E1; results are visible 2 cycles after start.
- Signed ops:
  - Operands are converted to magnitudes as unsigned NB_DATA values; 0x80000000 stays 0x80000000.
  - MULT: the 64-bit product is negated if sign_a^sign_b.
  - DIV: quotient is negated if sign_a^sign_b; remainder takes sign_a.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Results:
  - Multiply: HI = upper product word, LO = lower product word.
  - Divide: LO = quotient, HI = remainder.
  - Divide by zero (signed or unsigned): LO=0xFFFFFFFF, HI=i_data_a unchanged.
- o_stall = (i_start & state==IDLE) | o_busy | (i_mf_req & o_busy).
  - The start cycle stalls combinationally.
  - Stall drops in the cycle after FIX, so a dependent MFHI/MFLO reads the new values.
- MTHI/MTLO:
  - In IDLE without i_start, the write lands at the next edge.
  - Ignored when i_start is asserted in the same cycle (start wins) or while busy.
- i_start while busy: ignored; the pipeline is stalled, so a legal design never does this.
- Operands are captured only at start; later changes on i_data_a/b have no effect.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> o_done at cycle 33; HI=0xFFFFFFFE, LO=0x00000001; o_stall high cycles 0..33.
- MULT 0xFFFFFFFD (−3) × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV 0xFFFFFFF9 (−7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 0 -> o_done at cycle 1; LO=0xFFFFFFFF, HI=100; o_busy high for 1 cycle only.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0; DIVU 0x80000000 / 0xFFFFFFFF -> LO=0, HI=0x80000000.
- i_reset pulsed low at cycle 10 of a MULTU 5×6 -> immediately HI=LO=0, o_busy=0, o_stall=0; no o_done pulse; next MULTU 5×6 gives LO=30.
- MTHI 0x1234 in IDLE -> o_hi=0x1234 next cycle; MTLO with i_start same cycle, and MTHI during RUN -> LO and HI unchanged by the MT write; i_mf_req during RUN keeps o_stall=1 until cycle after o_done.
